// File: rtl/cpu_csr_access_ctl_if.sv
// Request/response channel between one CSR requester (CPU pipeline or debug module)
// and the CSR access controller.
interface cpu_csr_access_ctl_if;
    logic        req_valid;
    logic        req_ready;
    logic [11:0] req_addr;
    logic [1:0]  req_op;
    logic [31:0] req_data;
    logic        req_write;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_illegal;

    modport master (
        output req_valid, req_addr, req_op, req_data, req_write,
        input  req_ready, rsp_valid, rsp_data, rsp_illegal
    );

    modport slave (
        input  req_valid, req_addr, req_op, req_data, req_write,
        output req_ready, rsp_valid, rsp_data, rsp_illegal
    );
endinterface

// File: rtl/cpu_csr_access_ctl.sv
// Sequences Zicsr read-modify-write ops from the CPU and debug ports onto the
// single-port CSR file (registered read, separate write port).
module cpu_csr_access_ctl #(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    cpu_csr_access_ctl_if.slave         cpu,
    cpu_csr_access_ctl_if.slave         dbg,
    output logic [11:0]                 csr_read_addr_o,
    output logic                        csr_read_enable_o,
    input  logic [31:0]                 csr_read_data_i,
    output logic [11:0]                 csr_write_addr_o,
    output logic [31:0]                 csr_write_data_o,
    output logic                        csr_write_enable_o
);

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StFault} state_e;

    state_e      state_q, state_d;
    logic        prio_dbg_q, prio_dbg_d;  // 1: debug wins the next tie
    logic        gnt_dbg_q, gnt_dbg_d;    // port owning the op in flight
    logic [11:0] addr_q, addr_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] data_q, data_d;
    logic        write_q, write_d;

    logic        cpu_acc, dbg_acc;
    logic [11:0] sel_addr;
    logic        sel_write;
    logic [31:0] new_val;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_illegal;

    always_comb begin
        state_d            = state_q;
        prio_dbg_d         = prio_dbg_q;
        gnt_dbg_d          = gnt_dbg_q;
        addr_d             = addr_q;
        op_d               = op_q;
        data_d             = data_q;
        write_d            = write_q;
        cpu.req_ready      = 1'b0;
        dbg.req_ready      = 1'b0;
        cpu_acc            = 1'b0;
        dbg_acc            = 1'b0;
        sel_addr           = '0;
        sel_write          = 1'b0;
        new_val            = data_q;
        csr_read_addr_o    = '0;
        csr_read_enable_o  = 1'b0;
        csr_write_addr_o   = '0;
        csr_write_data_o   = '0;
        csr_write_enable_o = 1'b0;
        rsp_valid          = 1'b0;
        rsp_data           = '0;
        rsp_illegal        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!reset_i) begin
                    // The loser of a tie sees ready low so only one handshake completes.
                    cpu.req_ready = !(dbg.req_valid && (!ROUND_ROBIN || prio_dbg_q));
                    dbg.req_ready = !(cpu.req_valid && ROUND_ROBIN && !prio_dbg_q);
                end
                cpu_acc = cpu.req_valid && cpu.req_ready;
                dbg_acc = dbg.req_valid && dbg.req_ready;
                if (cpu_acc || dbg_acc) begin
                    sel_addr   = dbg_acc ? dbg.req_addr  : cpu.req_addr;
                    sel_write  = dbg_acc ? dbg.req_write : cpu.req_write;
                    addr_d     = sel_addr;
                    write_d    = sel_write;
                    op_d       = dbg_acc ? dbg.req_op   : cpu.req_op;
                    data_d     = dbg_acc ? dbg.req_data : cpu.req_data;
                    gnt_dbg_d  = dbg_acc;
                    prio_dbg_d = cpu_acc;
                    state_d    = (sel_write && sel_addr[11:10] == 2'b11) ? StFault : StRead;
                end
            end
            StRead: begin
                csr_read_enable_o = 1'b1;
                csr_read_addr_o   = addr_q;
                state_d           = StWrite;
            end
            StWrite: begin
                unique case (op_q)
                    2'b10:   new_val = csr_read_data_i | data_q;
                    2'b11:   new_val = csr_read_data_i & ~data_q;
                    default: new_val = data_q;
                endcase
                if (write_q) begin
                    csr_write_enable_o = 1'b1;
                    csr_write_addr_o   = addr_q;
                    csr_write_data_o   = new_val;
                end
                rsp_valid = 1'b1;
                rsp_data  = csr_read_data_i;
                state_d   = StIdle;
            end
            StFault: begin
                rsp_valid   = 1'b1;
                rsp_illegal = 1'b1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Reset aborts an op in flight: nothing leaves the block during the reset cycle.
        if (reset_i) begin
            csr_read_addr_o    = '0;
            csr_read_enable_o  = 1'b0;
            csr_write_addr_o   = '0;
            csr_write_data_o   = '0;
            csr_write_enable_o = 1'b0;
            rsp_valid          = 1'b0;
            rsp_data           = '0;
            rsp_illegal        = 1'b0;
        end
    end

    assign cpu.rsp_valid   = rsp_valid && !gnt_dbg_q;
    assign cpu.rsp_data    = cpu.rsp_valid ? rsp_data : '0;
    assign cpu.rsp_illegal = cpu.rsp_valid && rsp_illegal;
    assign dbg.rsp_valid   = rsp_valid && gnt_dbg_q;
    assign dbg.rsp_data    = dbg.rsp_valid ? rsp_data : '0;
    assign dbg.rsp_illegal = dbg.rsp_valid && rsp_illegal;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            prio_dbg_q <= 1'b0;
            gnt_dbg_q  <= 1'b0;
            addr_q     <= '0;
            op_q       <= '0;
            data_q     <= '0;
            write_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            prio_dbg_q <= prio_dbg_d;
            gnt_dbg_q  <= gnt_dbg_d;
            addr_q     <= addr_d;
            op_q       <= op_d;
            data_q     <= data_d;
            write_q    <= write_d;
        end
    end

endmodule

// File: tb/tb_cpu_csr_access_ctl.sv
// Directed bench for cpu_csr_access_ctl: a round-robin instance backed by a small CSR
// file model, plus a debug-priority instance used for the arbitration check.
module tb_cpu_csr_access_ctl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cpu_csr_access_ctl_if cpu_if ();
    cpu_csr_access_ctl_if dbg_if ();
    cpu_csr_access_ctl_if cpu2_if ();
    cpu_csr_access_ctl_if dbg2_if ();

    logic [11:0] rd_addr, wr_addr, rd_addr2, wr_addr2;
    logic        rd_en, wr_en, rd_en2, wr_en2;
    logic [31:0] rd_data, wr_data, wr_data2;

    cpu_csr_access_ctl #(.ROUND_ROBIN(1'b1)) dut (
        .clk_i              (clk),
        .reset_i            (reset),
        .cpu                (cpu_if),
        .dbg                (dbg_if),
        .csr_read_addr_o    (rd_addr),
        .csr_read_enable_o  (rd_en),
        .csr_read_data_i    (rd_data),
        .csr_write_addr_o   (wr_addr),
        .csr_write_data_o   (wr_data),
        .csr_write_enable_o (wr_en)
    );

    cpu_csr_access_ctl #(.ROUND_ROBIN(1'b0)) dut_fixed (
        .clk_i              (clk),
        .reset_i            (reset),
        .cpu                (cpu2_if),
        .dbg                (dbg2_if),
        .csr_read_addr_o    (rd_addr2),
        .csr_read_enable_o  (rd_en2),
        .csr_read_data_i    (32'h0),
        .csr_write_addr_o   (wr_addr2),
        .csr_write_data_o   (wr_data2),
        .csr_write_enable_o (wr_en2)
    );

    // CSR file model: registered read, write lands at the clock edge.
    logic [31:0] mscratch = 32'h0;
    logic [31:0] r341 = 32'h0;
    logic [31:0] cycle_cnt = 32'h0;
    logic [31:0] cyc_snap = 32'h0;
    always @(posedge clk) begin
        cycle_cnt <= cycle_cnt + 32'd1;
        if (rd_en) begin
            case (rd_addr)
                12'hC00: rd_data <= cycle_cnt;
                12'h340: rd_data <= mscratch;
                12'h341: rd_data <= r341;
                12'hF11: rd_data <= 32'h0000_0489;
                default: rd_data <= 32'h0;
            endcase
        end
        if (wr_en && wr_addr == 12'h340) mscratch <= wr_data;
        if (wr_en && wr_addr == 12'h341) r341 <= wr_data;
    end
    always @(negedge clk) if (rd_en && rd_addr == 12'hC00) cyc_snap <= cycle_cnt;

    int checks = 0;
    int failures = 0;

    // Drives one request and observes the four cycles after its accept.
    task automatic issue(input bit port, input logic [11:0] addr, input logic [1:0] op,
                         input logic [31:0] data, input logic wr, output int lat,
                         output logic [31:0] rdata, output logic ill, output logic saw_rd,
                         output logic saw_we, output logic [11:0] waddr,
                         output logic [31:0] wdata, output logic busy_rdy, output logic stray);
        bit acc = 1'b0;
        lat = -1; rdata = '0; ill = 1'b0; saw_rd = 1'b0; saw_we = 1'b0;
        waddr = '0; wdata = '0; busy_rdy = 1'b0; stray = 1'b0;
        @(posedge clk); #1;
        if (port) begin
            dbg_if.req_addr = addr; dbg_if.req_op = op; dbg_if.req_data = data;
            dbg_if.req_write = wr; dbg_if.req_valid = 1'b1;
        end else begin
            cpu_if.req_addr = addr; cpu_if.req_op = op; cpu_if.req_data = data;
            cpu_if.req_write = wr; cpu_if.req_valid = 1'b1;
        end
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            if (port ? dbg_if.req_ready : cpu_if.req_ready) acc = 1'b1;
            @(posedge clk); #1;
        end
        cpu_if.req_valid = 1'b0;
        dbg_if.req_valid = 1'b0;
        if (acc) begin
            for (int k = 1; k <= 4; k++) begin
                @(negedge clk);
                if (rd_en) saw_rd = 1'b1;
                if (wr_en) begin saw_we = 1'b1; waddr = wr_addr; wdata = wr_data; end
                if ((port ? dbg_if.rsp_valid : cpu_if.rsp_valid) && lat < 0) begin
                    lat   = k;
                    rdata = port ? dbg_if.rsp_data : cpu_if.rsp_data;
                    ill   = port ? dbg_if.rsp_illegal : cpu_if.rsp_illegal;
                end
                if (port ? cpu_if.rsp_valid : dbg_if.rsp_valid) stray = 1'b1;
                if ((lat < 0 || lat == k) && (cpu_if.req_ready || dbg_if.req_ready))
                    busy_rdy = 1'b1;
            end
        end
    endtask

    int          lat;
    logic [31:0] rdata, wdata;
    logic [11:0] waddr;
    logic        ill, saw_rd, saw_we, busy_rdy, stray;

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++;
        if ({cpu_if.req_ready, dbg_if.req_ready, rd_en, wr_en, cpu_if.rsp_valid,
             dbg_if.rsp_valid} !== 6'b0) begin
            failures++; $display("FAIL reset_outputs got=%b exp=000000",
                {cpu_if.req_ready, dbg_if.req_ready, rd_en, wr_en, cpu_if.rsp_valid,
                 dbg_if.rsp_valid});
        end
        checks++;
        if ({rd_addr, wr_addr, wr_data, cpu_if.rsp_data} !== 88'h0) begin
            failures++; $display("FAIL reset_buses got=%h exp=0",
                {rd_addr, wr_addr, wr_data, cpu_if.rsp_data});
        end
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({cpu_if.req_ready, dbg_if.req_ready} !== 2'b11) begin
            failures++; $display("FAIL idle_ready got=%b exp=11",
                {cpu_if.req_ready, dbg_if.req_ready});
        end
    endtask

    task automatic test_rw;
        issue(1'b0, 12'h340, 2'b01, 32'hDEAD_BEEF, 1'b1, lat, rdata, ill, saw_rd, saw_we,
              waddr, wdata, busy_rdy, stray);
        checks++;
        if (lat !== 2) begin failures++; $display("FAIL rw_latency got=%0d exp=2", lat); end
        checks++;
        if (rdata !== 32'h0 || ill !== 1'b0) begin
            failures++; $display("FAIL rw_rsp got=%h/%b exp=00000000/0", rdata, ill);
        end
        checks++;
        if ({saw_rd, saw_we, waddr, wdata} !== {2'b11, 12'h340, 32'hDEAD_BEEF}) begin
            failures++; $display("FAIL rw_write got=%b%b %h %h exp=11 340 deadbeef",
                saw_rd, saw_we, waddr, wdata);
        end
        checks++;
        if (busy_rdy !== 1'b0 || stray !== 1'b0) begin
            failures++; $display("FAIL rw_busy got=%b%b exp=00", busy_rdy, stray);
        end
        issue(1'b0, 12'h340, 2'b10, 32'h0, 1'b0, lat, rdata, ill, saw_rd, saw_we,
              waddr, wdata, busy_rdy, stray);
        checks++;
        if (rdata !== 32'hDEAD_BEEF || saw_we !== 1'b0) begin
            failures++; $display("FAIL rw_readback got=%h we=%b exp=deadbeef we=0",
                rdata, saw_we);
        end
    endtask

    task automatic test_set_clear;
        issue(1'b0, 12'h340, 2'b01, 32'h0000_000F, 1'b1, lat, rdata, ill, saw_rd, saw_we,
              waddr, wdata, busy_rdy, stray);
        issue(1'b0, 12'h340, 2'b10, 32'h0000_00F0, 1'b1, lat, rdata, ill, saw_rd, saw_we,
              waddr, wdata, busy_rdy, stray);
        checks++;
        if ({rdata, wdata, saw_we} !== {32'h0F, 32'hFF, 1'b1}) begin
            failures++; $display("FAIL rs got=%h %h we=%b exp=0000000f 000000ff we=1",
                rdata, wdata, saw_we);
        end
        issue(1'b0, 12'h340, 2'b11, 32'h0000_000F, 1'b1, lat, rdata, ill, saw_rd, saw_we,
              waddr, wdata, busy_rdy, stray);
        checks++;
        if ({rdata, wdata, saw_we} !== {32'hFF, 32'hF0, 1'b1}) begin
            failures++; $display("FAIL rc got=%h %h we=%b exp=000000ff 000000f0 we=1",
                rdata, wdata, saw_we);
        end
        // op 00 behaves as RW
        issue(1'b0, 12'h341, 2'b00, 32'h0000_00A5, 1'b1, lat, rdata, ill, saw_rd, saw_we,
              waddr, wdata, busy_rdy, stray);
        checks++;
        if ({waddr, wdata, saw_we} !== {12'h341, 32'hA5, 1'b1}) begin
            failures++; $display("FAIL op00 got=%h %h we=%b exp=341 000000a5 we=1",
                waddr, wdata, saw_we);
        end
        issue(1'b1, 12'h340, 2'b11, 32'h0000_0030, 1'b1, lat, rdata, ill, saw_rd, saw_we,
              waddr, wdata, busy_rdy, stray);
        checks++;
        if ({lat == 2, rdata, wdata, stray} !== {1'b1, 32'hF0, 32'hC0, 1'b0}) begin
            failures++; $display("FAIL dbg_rc got=lat%0d %h %h stray=%b exp=lat2 f0 c0 stray=0",
                lat, rdata, wdata, stray);
        end
    endtask

    task automatic test_read_only;
        issue(1'b0, 12'hC00, 2'b10, 32'h0, 1'b0, lat, rdata, ill, saw_rd, saw_we,
              waddr, wdata, busy_rdy, stray);
        checks++;
        if ({lat == 2, rdata, ill, saw_rd, saw_we} !== {1'b1, cyc_snap, 3'b010}) begin
            failures++; $display("FAIL cycle_read got=lat%0d %h %b%b%b exp=lat2 %h 010",
                lat, rdata, ill, saw_rd, saw_we, cyc_snap);
        end
        issue(1'b0, 12'hF11, 2'b10, 32'h0, 1'b0, lat, rdata, ill, saw_rd, saw_we,
              waddr, wdata, busy_rdy, stray);
        checks++;
        if ({lat == 2, rdata, ill, saw_we} !== {1'b1, 32'h489, 2'b00}) begin
            failures++; $display("FAIL ro_legal_read got=lat%0d %h %b%b exp=lat2 489 00",
                lat, rdata, ill, saw_we);
        end
    endtask

    task automatic test_fault;
        issue(1'b0, 12'hF11, 2'b01, 32'h5555_5555, 1'b1, lat, rdata, ill, saw_rd, saw_we,
              waddr, wdata, busy_rdy, stray);
        checks++;
        if (lat !== 1) begin failures++; $display("FAIL fault_latency got=%0d exp=1", lat); end
        checks++;
        if ({ill, rdata, saw_rd, saw_we, busy_rdy} !== {1'b1, 32'h0, 3'b000}) begin
            failures++; $display("FAIL fault_rsp got=%b %h %b%b%b exp=1 00000000 000",
                ill, rdata, saw_rd, saw_we, busy_rdy);
        end
    endtask

    task automatic test_reset_abort;
        @(posedge clk); #1;
        cpu_if.req_addr = 12'h340; cpu_if.req_op = 2'b01; cpu_if.req_data = 32'h1234;
        cpu_if.req_write = 1'b1; cpu_if.req_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (cpu_if.req_ready !== 1'b1) begin
            failures++; $display("FAIL abort_accept got=%b exp=1", cpu_if.req_ready);
        end
        @(posedge clk); #1 cpu_if.req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (rd_en !== 1'b1) begin failures++; $display("FAIL abort_read got=%b exp=1", rd_en); end
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({wr_en, cpu_if.rsp_valid, dbg_if.rsp_valid} !== 3'b000) begin
            failures++; $display("FAIL abort_quiet got=%b%b%b exp=000",
                wr_en, cpu_if.rsp_valid, dbg_if.rsp_valid);
        end
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({cpu_if.req_ready, rd_en, cpu_if.rsp_valid} !== 3'b100) begin
            failures++; $display("FAIL abort_idle got=%b%b%b exp=100",
                cpu_if.req_ready, rd_en, cpu_if.rsp_valid);
        end
        issue(1'b0, 12'h340, 2'b10, 32'h0, 1'b0, lat, rdata, ill, saw_rd, saw_we,
              waddr, wdata, busy_rdy, stray);
        checks++;
        if (rdata !== 32'hC0) begin
            failures++; $display("FAIL abort_unchanged got=%h exp=000000c0", rdata);
        end
    endtask

    task automatic test_arbitration;
        int q1[$];
        int q2[$];
        int n_dbg2 = 0;
        int exp1[3] = '{0, 1, 0};
        int exp2[4] = '{1, 1, 1, 0};
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        cpu_if.req_addr = 12'h340; cpu_if.req_op = 2'b10; cpu_if.req_data = 32'h0;
        cpu_if.req_write = 1'b0; cpu_if.req_valid = 1'b1;
        dbg_if.req_addr = 12'h341; dbg_if.req_op = 2'b10; dbg_if.req_data = 32'h0;
        dbg_if.req_write = 1'b0; dbg_if.req_valid = 1'b1;
        cpu2_if.req_addr = 12'h340; cpu2_if.req_op = 2'b10; cpu2_if.req_data = 32'h0;
        cpu2_if.req_write = 1'b0; cpu2_if.req_valid = 1'b1;
        dbg2_if.req_addr = 12'h341; dbg2_if.req_op = 2'b10; dbg2_if.req_data = 32'h0;
        dbg2_if.req_write = 1'b0; dbg2_if.req_valid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (cpu_if.req_valid && cpu_if.req_ready) q1.push_back(0);
            if (dbg_if.req_valid && dbg_if.req_ready) q1.push_back(1);
            if (cpu2_if.req_valid && cpu2_if.req_ready) q2.push_back(0);
            if (dbg2_if.req_valid && dbg2_if.req_ready) begin q2.push_back(1); n_dbg2++; end
            @(posedge clk); #1;
            if (q1.size() >= 3) begin cpu_if.req_valid = 1'b0; dbg_if.req_valid = 1'b0; end
            if (n_dbg2 >= 3) dbg2_if.req_valid = 1'b0;
            if (q2.size() >= 4) cpu2_if.req_valid = 1'b0;
        end
        checks++;
        if (q1.size() != 3) begin
            failures++; $display("FAIL rr_grant_count got=%0d exp=3", q1.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (q1[i] != exp1[i]) begin
                    failures++; $display("FAIL rr_grant[%0d] got=%0d exp=%0d", i, q1[i], exp1[i]);
                end
            end
        end
        checks++;
        if (q2.size() != 4) begin
            failures++; $display("FAIL fixed_grant_count got=%0d exp=4", q2.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (q2[i] != exp2[i]) begin
                    failures++; $display("FAIL fixed_grant[%0d] got=%0d exp=%0d",
                        i, q2[i], exp2[i]);
                end
            end
        end
    endtask

    initial begin
        cpu_if.req_valid = 1'b0; cpu_if.req_addr = '0; cpu_if.req_op = '0;
        cpu_if.req_data = '0; cpu_if.req_write = 1'b0;
        dbg_if.req_valid = 1'b0; dbg_if.req_addr = '0; dbg_if.req_op = '0;
        dbg_if.req_data = '0; dbg_if.req_write = 1'b0;
        cpu2_if.req_valid = 1'b0; cpu2_if.req_addr = '0; cpu2_if.req_op = '0;
        cpu2_if.req_data = '0; cpu2_if.req_write = 1'b0;
        dbg2_if.req_valid = 1'b0; dbg2_if.req_addr = '0; dbg2_if.req_op = '0;
        dbg2_if.req_data = '0; dbg2_if.req_write = 1'b0;
        test_reset();
        test_rw();
        test_set_clear();
        test_read_only();
        test_fault();
        test_reset_abort();
        test_arbitration();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
